// File: rtl/traffic_phase_controller.sv
// N-approach signal sequencer: green/yellow/all-red per phase, demand skip, rest-in-main, night flash.
// Interval timing advances only on tick; lamps decode from registers with no input path; no backpressure.
module traffic_phase_controller #(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 4,
    parameter int GREEN_TIME  = 7,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] req,
    input  logic                  flash,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] green,
    output logic [PH_W-1:0]       active_phase,
    output logic [CNT_W-1:0]      countdown,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_ALLRED = 2'b10,
        S_FLASH  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] G_LD    = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] Y_LD    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] A_LD    = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PH_W:0]    NP      = (PH_W + 1)'(NUM_PHASES);
    localparam logic [NUM_PHASES-1:0] DEM0 = NUM_PHASES'(1);

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d, next_ph;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_PHASES-1:0]   dem_q, dem_d, phase_sel, ign_mask, clr_mask, dem_rot;
    logic [2*NUM_PHASES-1:0] dem_dbl;
    logic [PH_W:0]           cand;
    logic                    blink_q, blink_d;
    logic                    aff_q, aff_d;
    logic                    expire, side_dem, enter_green;

    assign expire    = tick && (cnt_q == '0);
    assign side_dem  = |dem_q[NUM_PHASES-1:1];
    assign phase_sel = DEM0 << phase_q;
    assign dem_dbl   = {dem_q, dem_q};
    assign dem_rot   = dem_dbl[phase_q +: NUM_PHASES];

    // dem_rot[j] is demand of phase (active+j) mod N; the lowest j wins, phase 0 is always set.
    always_comb begin
        next_ph = '0;
        cand    = '0;
        for (int j = NUM_PHASES - 1; j >= 1; j--) begin
            if (dem_rot[j]) begin
                cand = {1'b0, phase_q} + (PH_W + 1)'(j);
                if (cand >= NP) cand = cand - NP;
                next_ph = cand[PH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        blink_d     = blink_q;
        aff_d       = aff_q;
        enter_green = 1'b0;
        if (tick && cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        case (state_q)
            S_GREEN: begin
                if (expire && (phase_q != '0 || side_dem || flash)) begin
                    state_d = S_YELLOW;
                    cnt_d   = Y_LD;
                end
            end
            S_YELLOW: begin
                if (expire) begin
                    state_d = S_ALLRED;
                    cnt_d   = A_LD;
                end
            end
            S_ALLRED: begin
                if (expire) begin
                    aff_d = 1'b0;
                    if (flash) begin
                        state_d = S_FLASH;
                        phase_d = '0;
                        cnt_d   = '0;
                        blink_d = 1'b1;
                    end else begin
                        state_d     = S_GREEN;
                        phase_d     = aff_q ? '0 : next_ph;
                        cnt_d       = G_LD;
                        enter_green = 1'b1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    blink_d = ~blink_q;
                    if (!flash) begin
                        state_d = S_ALLRED;
                        cnt_d   = A_LD;
                        aff_d   = 1'b1;
                        blink_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // The served phase cannot re-request itself while green or yellow.
    always_comb begin
        ign_mask = (state_q == S_GREEN || state_q == S_YELLOW) ? phase_sel : '0;
        clr_mask = enter_green ? (DEM0 << phase_d) : '0;
        dem_d    = ((dem_q | (req & ~ign_mask)) & ~clr_mask) | DEM0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_GREEN;
            phase_q <= '0;
            cnt_q   <= G_LD;
            dem_q   <= DEM0;
            blink_q <= 1'b0;
            aff_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            dem_q   <= dem_d;
            blink_q <= blink_d;
            aff_q   <= aff_d;
        end
    end

    always_comb begin
        red    = '1;
        yellow = '0;
        green  = '0;
        case (state_q)
            S_GREEN: begin
                green = phase_sel;
                red   = ~phase_sel;
            end
            S_YELLOW: begin
                yellow = phase_sel;
                red    = ~phase_sel;
            end
            S_ALLRED: red = '1;
            default: begin
                red    = '0;
                yellow = {NUM_PHASES{blink_q}};
            end
        endcase
    end

    assign active_phase = phase_q;
    assign countdown    = cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: vector table, directed multi-cycle sequences and a
// randomized run against a rule-level reference model; also a 2-phase instance for alternation.
module tb_traffic_phase_controller;
    localparam int N  = 4;
    localparam int GT = 7;
    localparam int YT = 2;
    localparam int AT = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] req = '0;
    logic       flash = 1'b0;
    logic [3:0] red, yellow, green;
    logic [1:0] active_phase;
    logic [3:0] countdown;
    logic [1:0] state_o;

    logic [1:0] req2 = '0;
    logic [1:0] red2, yellow2, green2;
    logic [0:0] ap2;
    logic [3:0] cd2;
    logic [1:0] st2;

    int checks = 0;
    int errors = 0;

    traffic_phase_controller #(.NUM_PHASES(N), .CNT_W(4), .GREEN_TIME(GT), .YELLOW_TIME(YT),
                               .ALLRED_TIME(AT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req), .flash(flash),
        .red(red), .yellow(yellow), .green(green), .active_phase(active_phase),
        .countdown(countdown), .state_o(state_o));

    traffic_phase_controller #(.NUM_PHASES(2), .CNT_W(4), .GREEN_TIME(GT), .YELLOW_TIME(YT),
                               .ALLRED_TIME(AT)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .req(req2), .flash(flash),
        .red(red2), .yellow(yellow2), .green(green2), .active_phase(ap2),
        .countdown(cd2), .state_o(st2));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: mode 0 green, 1 yellow, 2 all-red, 3 flash; rem = ticks left in interval.
    int         m_mode, m_ph, m_rem;
    logic [3:0] m_dem;
    logic       m_blink, m_aff;

    function automatic int pick(input int from, input logic [3:0] d);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (from + k) % N;
            if (j == 0 || d[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_step();
        logic [3:0] old, nd;
        if (reset) begin
            m_mode = 0; m_ph = 0; m_rem = GT; m_dem = '0; m_blink = 1'b0; m_aff = 1'b0;
            return;
        end
        old = m_dem;
        nd  = m_dem;
        for (int i = 1; i < N; i++)
            if (req[i] && !(m_mode <= 1 && m_ph == i)) nd[i] = 1'b1;
        if (tick) begin
            case (m_mode)
                0: if (m_rem > 1) m_rem--;
                   else if (m_ph != 0 || old[3:1] != 0 || flash) begin m_mode = 1; m_rem = YT; end
                1: if (m_rem > 1) m_rem--;
                   else begin m_mode = 2; m_rem = AT; end
                2: if (m_rem > 1) m_rem--;
                   else if (flash) begin m_mode = 3; m_ph = 0; m_blink = 1'b1; end
                   else begin
                       m_ph = m_aff ? 0 : pick(m_ph, old);
                       m_mode = 0; m_rem = GT; m_aff = 1'b0;
                       nd[m_ph] = 1'b0;
                   end
                default: begin
                    m_blink = !m_blink;
                    if (!flash) begin m_mode = 2; m_rem = AT; m_aff = 1'b1; end
                end
            endcase
        end
        m_dem = nd;
    endtask

    task automatic model_check();
        logic [3:0] sel, eg, ey, er;
        sel = (m_mode <= 1) ? (4'b0001 << m_ph) : 4'b0000;
        eg  = (m_mode == 0) ? sel : 4'b0000;
        ey  = (m_mode == 1) ? sel : ((m_mode == 3) ? {4{m_blink}} : 4'b0000);
        er  = (m_mode == 3) ? 4'b0000 : ~sel;
        chk("model_state", 32'(state_o), m_mode);
        chk("model_phase", 32'(active_phase), m_ph);
        chk("model_countdown", 32'(countdown), (m_mode == 3) ? 0 : m_rem - 1);
        chk("model_green", 32'(green), 32'(eg));
        chk("model_yellow", 32'(yellow), 32'(ey));
        chk("model_red", 32'(red), 32'(er));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic       rs, tk, fl;
        logic [3:0] rq;
        logic [1:0] st, ph;
        logic [3:0] cd, g, y, r;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic rs, input logic tk, input logic [3:0] rq, input logic fl,
                       input logic [1:0] st, input logic [1:0] ph, input logic [3:0] cd,
                       input logic [3:0] g, input logic [3:0] y, input logic [3:0] r);
        vec_t v;
        v.rs = rs; v.tk = tk; v.rq = rq; v.fl = fl; v.st = st; v.ph = ph;
        v.cd = cd; v.g = g; v.y = y; v.r = r;
        vt.push_back(v);
    endtask

    initial begin
        int found, g1, y1, ar, bad, prev_cd, run;
        int seq4[$], seq2[$], runs[$];
        int e4[4];
        int e2[3];
        logic [3:0] pg;
        logic [1:0] pg2;

        // Single demand for phase 2: serve it once, then rest on phase 0.
        add(1, 0, 4'b0000, 0, 2'd0, 2'd0, 4'd6, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd0, 4'd5, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd0, 4'd4, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0100, 0, 2'd0, 2'd0, 4'd3, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd0, 4'd2, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd0, 4'd1, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd0, 4'd0, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd1, 2'd0, 4'd1, 4'b0000, 4'b0001, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd1, 2'd0, 4'd0, 4'b0000, 4'b0001, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd2, 2'd0, 4'd0, 4'b0000, 4'b0000, 4'b1111);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd2, 4'd6, 4'b0100, 4'b0000, 4'b1011);
        for (int c = 5; c >= 0; c--)
            add(0, 1, 4'b0000, 0, 2'd0, 2'd2, 4'(c), 4'b0100, 4'b0000, 4'b1011);
        add(0, 1, 4'b0000, 0, 2'd1, 2'd2, 4'd1, 4'b0000, 4'b0100, 4'b1011);
        add(0, 1, 4'b0000, 0, 2'd1, 2'd2, 4'd0, 4'b0000, 4'b0100, 4'b1011);
        add(0, 1, 4'b0000, 0, 2'd2, 2'd2, 4'd0, 4'b0000, 4'b0000, 4'b1111);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd0, 4'd6, 4'b0001, 4'b0000, 4'b1110);
        add(0, 1, 4'b0000, 0, 2'd0, 2'd0, 4'd5, 4'b0001, 4'b0000, 4'b1110);

        foreach (vt[i]) begin
            reset = vt[i].rs; tick = vt[i].tk; req = vt[i].rq; flash = vt[i].fl;
            cycle();
            chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(vt[i].st));
            chk($sformatf("tbl%0d_phase", i), 32'(active_phase), 32'(vt[i].ph));
            chk($sformatf("tbl%0d_count", i), 32'(countdown), 32'(vt[i].cd));
            chk($sformatf("tbl%0d_green", i), 32'(green), 32'(vt[i].g));
            chk($sformatf("tbl%0d_yellow", i), 32'(yellow), 32'(vt[i].y));
            chk($sformatf("tbl%0d_red", i), 32'(red), 32'(vt[i].r));
        end
        reset = 1'b0; req = '0;

        // Rest in main with no demand.
        reset = 1'b1; tick = 1'b1; cycle(); reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (state_o != 2'b00) bad++;
        end
        chk("rest_state_nonzero_cycles", bad, 0);
        chk("rest_countdown", 32'(countdown), 0);
        chk("rest_green", 32'(green), 1);

        // Two demands together: order 0,1,3,0, plus 0,1,0 on the 2-phase build.
        pg = '0; pg2 = '0; run = 0;
        for (int i = 0; i < 60; i++) begin
            reset = (i == 0); tick = 1'b1;
            req  = (i == 2) ? 4'b1010 : 4'b0000;
            req2 = (i == 2) ? 2'b10 : 2'b00;
            cycle();
            if (green != 0) begin
                if (green != pg) begin seq4.push_back($clog2(green)); run = 1; end
                else run++;
            end else if (pg != 0) runs.push_back(run);
            if (green2 != 0 && green2 != pg2) seq2.push_back($clog2(green2));
            pg = green; pg2 = green2;
        end
        req = '0; req2 = '0;
        e4 = '{0, 1, 3, 0};
        e2 = '{0, 1, 0};
        chk("order4_len", seq4.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("order4_%0d", k), (k < seq4.size()) ? seq4[k] : -1, e4[k]);
        chk("green_runs_len", runs.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("green_run_%0d", k), (k < runs.size()) ? runs[k] : -1, 7);
        chk("order2_len", seq2.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("order2_%0d", k), (k < seq2.size()) ? seq2[k] : -1, e2[k]);

        // Tick every 4th cycle with req[1] held.
        reset = 1'b1; tick = 1'b0; cycle(); reset = 1'b0;
        g1 = 0; y1 = 0; ar = 0; bad = 0; found = 0; prev_cd = 32'(countdown);
        for (int k = 0; k < 400 && found == 0; k++) begin
            tick = (k % 4 == 3); req = 4'b0010;
            cycle();
            if (32'(countdown) != prev_cd && !tick) bad++;
            prev_cd = 32'(countdown);
            if (green[1]) g1++;
            if (yellow[1]) y1++;
            if (y1 > 0 && state_o == 2'b10 && active_phase == 2'd1) ar++;
            if (ar > 0 && state_o == 2'b00) found = 1;
        end
        req = '0; tick = 1'b1;
        chk("slow_done", found, 1);
        chk("slow_cnt_off_tick", bad, 0);
        chk("slow_green_clks", g1, 28);
        chk("slow_yellow_clks", y1, 8);
        chk("slow_allred_clks", ar, 4);

        // Flash requested during phase 1 green.
        reset = 1'b1; cycle(); reset = 1'b0;
        req = 4'b0010; cycle(); req = '0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            cycle();
            if (green[1]) found = 1;
        end
        chk("flash_g1_reached", found, 1);
        flash = 1'b1; g1 = 1; found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            cycle();
            if (green[1]) g1++;
            if (state_o == 2'b11) found = 1;
        end
        chk("flash_entry", found, 1);
        chk("flash_g1_full_len", g1, 7);
        chk("flash_y_on", 32'(yellow), 32'hf);
        chk("flash_red_off", 32'(red), 0);
        chk("flash_green_off", 32'(green), 0);
        req = 4'b0100; cycle(); req = '0;
        chk("flash_y_blink_off", 32'(yellow), 0);
        cycle();
        chk("flash_y_blink_on", 32'(yellow), 32'hf);
        flash = 1'b0; cycle();
        chk("flash_exit_state", 32'(state_o), 2);
        chk("flash_exit_red", 32'(red), 32'hf);
        chk("flash_exit_count", 32'(countdown), 0);
        cycle();
        chk("flash_back_state", 32'(state_o), 0);
        chk("flash_back_phase", 32'(active_phase), 0);
        chk("flash_back_green", 32'(green), 1);

        // Reset mid-yellow on a non-tick cycle discards pending demand.
        reset = 1'b1; cycle(); reset = 1'b0;
        req = 4'b0100; cycle(); req = '0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (state_o == 2'b01) found = 1;
        end
        chk("rst_yellow_reached", found, 1);
        tick = 1'b0; reset = 1'b1; cycle();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_phase", 32'(active_phase), 0);
        chk("rst_count", 32'(countdown), 6);
        chk("rst_green", 32'(green), 1);
        chk("rst_red", 32'(red), 32'he);
        reset = 1'b0; tick = 1'b1; bad = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (green[2] || green[1]) bad++;
        end
        chk("rst_no_stale_service", bad, 0);

        // Randomized run against the model.
        reset = 1'b1; cycle();
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            tick  = ($urandom_range(0, 2) != 0);
            req   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 99) == 0) flash = !flash;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
